// File: rtl/rggen_atomic_wide_register_common_pkg.sv
// Shared definitions for the atomic wide register front end: bus access
// encoding, response status and word-index sizing.
package rggen_atomic_wide_register_common_pkg;

    // Bit 0 of the access code distinguishes writes from reads.
    localparam int RGGEN_ACCESS_DATA_BIT = 0;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    // Width of a word index; a single-word register still needs one bit.
    function automatic int word_index_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rggen_atomic_wide_register_common_buffer.sv
// Staging and snapshot storage for one wide register. Staged writes are
// merged byte-wise per bus word; the snapshot holds a full-register capture
// taken by the latch-word read.
module rggen_wide_register_buffer
    import rggen_atomic_wide_register_common_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BUS_WIDTH  = 32,
    localparam int INDEX_WIDTH = word_index_width(DATA_WIDTH / BUS_WIDTH)
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   stage_en,
    input  logic [INDEX_WIDTH-1:0] word_index,
    input  logic [BUS_WIDTH-1:0]   write_data,
    input  logic [BUS_WIDTH-1:0]   write_mask,
    input  logic                   clear_staged,
    input  logic                   clear_snap,
    input  logic                   capture,
    input  logic [DATA_WIDTH-1:0]  capture_data,
    output logic [DATA_WIDTH-1:0]  staged_data,
    output logic [DATA_WIDTH-1:0]  staged_mask,
    output logic [DATA_WIDTH-1:0]  snap_data,
    output logic                   snap_valid
);

    // Merge new bytes into the staged word; the commit only drops the mask.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            staged_data <= '0;
            staged_mask <= '0;
        end else if (stage_en) begin
            staged_data[word_index*BUS_WIDTH+:BUS_WIDTH] <=
                (staged_data[word_index*BUS_WIDTH+:BUS_WIDTH] & ~write_mask) |
                (write_data & write_mask);
            staged_mask[word_index*BUS_WIDTH+:BUS_WIDTH] <=
                staged_mask[word_index*BUS_WIDTH+:BUS_WIDTH] | write_mask;
        end else if (clear_staged) begin
            staged_mask <= '0;
        end
    end

    // Capture the whole register on a latch read; writes invalidate it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_data  <= '0;
            snap_valid <= 1'b0;
        end else if (capture) begin
            snap_data  <= capture_data;
            snap_valid <= 1'b1;
        end else if (clear_snap) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rggen_atomic_wide_register_common.sv
// Register front end for a register wider than the bus. Lower-word writes
// are staged and committed together by the commit word; a read of the latch
// word snapshots the register so the other words read back coherently.
// Handshake: a transfer happens in any cycle where register_valid and
// register_active are both high; ready follows active, so there are no
// wait states and the bit-field side sees the access in the same cycle.
module rggen_atomic_wide_register_common
    import rggen_atomic_wide_register_common_pkg::*;
#(
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1,
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                     BUS_WIDTH      = 32,
    parameter int                     DATA_WIDTH     = 64,
    parameter bit                     ATOMIC_WRITE   = 1'b1,
    parameter bit                     ATOMIC_READ    = 1'b1,
    parameter int                     COMMIT_INDEX   = (DATA_WIDTH / BUS_WIDTH) - 1,
    parameter int                     LATCH_INDEX    = 0
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     register_valid,
    input  logic [1:0]               register_access,
    input  logic [ADDRESS_WIDTH-1:0] register_address,
    input  logic [BUS_WIDTH-1:0]     register_write_data,
    input  logic [BUS_WIDTH/8-1:0]   register_strobe,
    output logic                     register_active,
    output logic                     register_ready,
    output logic [1:0]               register_status,
    output logic [BUS_WIDTH-1:0]     register_read_data,
    output logic [DATA_WIDTH-1:0]    register_value,
    input  logic                     i_additional_match,
    output logic                     bit_field_valid,
    output logic [DATA_WIDTH-1:0]    bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]    bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]    bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    bit_field_value
);

    localparam int WORDS       = DATA_WIDTH / BUS_WIDTH;
    localparam int BUS_BYTES   = BUS_WIDTH / 8;
    localparam int INDEX_WIDTH = word_index_width(WORDS);
    localparam bit STAGING     = ATOMIC_WRITE && (WORDS > 1);
    localparam bit SNAPSHOT    = ATOMIC_READ && (WORDS > 1);

    logic                   is_write;
    logic                   access_ok;
    logic                   handshake;
    logic [WORDS-1:0]       match;
    logic [INDEX_WIDTH-1:0] word_index;
    logic [BUS_WIDTH-1:0]   bus_mask;
    logic                   stage_en;
    logic                   clear_staged;
    logic                   clear_snap;
    logic                   capture;
    logic [DATA_WIDTH-1:0]  staged_data;
    logic [DATA_WIDTH-1:0]  staged_mask;
    logic [DATA_WIDTH-1:0]  snap_data;
    logic                   snap_valid;
    logic                   unused_access;

    // The posted/non-posted distinction makes no difference here.
    assign unused_access = register_access[1];
    assign is_write      = register_access[RGGEN_ACCESS_DATA_BIT];
    assign access_ok     = is_write ? WRITABLE : READABLE;

    // Per-word decode by offset from the word base, which wraps cleanly.
    for (genvar g = 0; g < WORDS; g++) begin : g_decode
        localparam logic [ADDRESS_WIDTH-1:0] WORD_START =
            ADDRESS_WIDTH'(OFFSET_ADDRESS + g * BUS_BYTES);
        logic [ADDRESS_WIDTH-1:0] relative;
        assign relative = register_address - WORD_START;
        assign match[g] = (relative < ADDRESS_WIDTH'(BUS_BYTES)) &&
                          access_ok && i_additional_match;
    end

    // Encode the one-hot word match into an index.
    always_comb begin
        word_index = '0;
        for (int g = 0; g < WORDS; g++) begin
            if (match[g]) begin
                word_index = INDEX_WIDTH'(g);
            end
        end
    end

    // Expand byte strobes to a bit mask.
    always_comb begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            bus_mask[i] = register_strobe[i/8];
        end
    end

    assign register_active = |match;
    assign register_ready  = register_active;
    assign register_status = RGGEN_OKAY;
    assign register_value  = bit_field_value;
    assign handshake       = register_valid && register_active;

    // Route each access to staging, snapshot or the bit fields.
    always_comb begin
        bit_field_valid      = 1'b0;
        bit_field_read_mask  = '0;
        bit_field_write_mask = '0;
        bit_field_write_data = '0;
        register_read_data   = '0;
        stage_en             = 1'b0;
        clear_staged         = 1'b0;
        clear_snap           = 1'b0;
        capture              = 1'b0;
        if (register_active) begin
            if (is_write) begin
                if (STAGING && (word_index != INDEX_WIDTH'(COMMIT_INDEX))) begin
                    stage_en = handshake;
                end else begin
                    bit_field_valid = register_valid;
                    clear_snap      = handshake;
                    if (STAGING) begin
                        bit_field_write_mask = staged_mask;
                        bit_field_write_data = staged_data;
                        clear_staged         = handshake;
                    end
                    bit_field_write_mask[word_index*BUS_WIDTH+:BUS_WIDTH] =
                        bit_field_write_mask[word_index*BUS_WIDTH+:BUS_WIDTH] | bus_mask;
                    bit_field_write_data[word_index*BUS_WIDTH+:BUS_WIDTH] =
                        register_write_data;
                end
            end else begin
                if (SNAPSHOT && (word_index == INDEX_WIDTH'(LATCH_INDEX))) begin
                    bit_field_valid     = register_valid;
                    bit_field_read_mask = '1;
                    register_read_data  = bit_field_read_data[word_index*BUS_WIDTH+:BUS_WIDTH];
                    capture             = handshake;
                end else if (SNAPSHOT && snap_valid) begin
                    register_read_data = snap_data[word_index*BUS_WIDTH+:BUS_WIDTH];
                end else begin
                    bit_field_valid = register_valid;
                    bit_field_read_mask[word_index*BUS_WIDTH+:BUS_WIDTH] = '1;
                    register_read_data = bit_field_read_data[word_index*BUS_WIDTH+:BUS_WIDTH];
                end
            end
        end
    end

    rggen_wide_register_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_buffer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .stage_en     (stage_en),
        .word_index   (word_index),
        .write_data   (register_write_data),
        .write_mask   (bus_mask),
        .clear_staged (clear_staged),
        .clear_snap   (clear_snap),
        .capture      (capture),
        .capture_data (bit_field_read_data),
        .staged_data  (staged_data),
        .staged_mask  (staged_mask),
        .snap_data    (snap_data),
        .snap_valid   (snap_valid)
    );

    // Word ranges never overlap, so at most one word may decode.
    a_single_match: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(match));

endmodule

// File: tb/tb_rggen_atomic_wide_register_common.sv
// Directed bench for the atomic wide register front end: a vector table
// applied back to back, then reset and non-atomic-write sequences.
module tb_rggen_atomic_wide_register_common;
    import rggen_atomic_wide_register_common_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        reg_valid;
    logic [1:0]  reg_access;
    logic [7:0]  reg_address;
    logic [31:0] reg_write_data;
    logic [3:0]  reg_strobe;
    logic        add_match;
    logic [63:0] field;

    logic        a_active, a_ready, a_valid;
    logic [1:0]  a_status;
    logic [31:0] a_rdata;
    logic [63:0] a_value, a_rmask, a_wmask, a_wdata;
    logic        n_active, n_ready, n_valid;
    logic [1:0]  n_status;
    logic [31:0] n_rdata;
    logic [63:0] n_value, n_rmask, n_wmask, n_wdata;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rggen_atomic_wide_register_common #(
        .OFFSET_ADDRESS (8'h10)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .register_valid       (reg_valid),
        .register_access      (reg_access),
        .register_address     (reg_address),
        .register_write_data  (reg_write_data),
        .register_strobe      (reg_strobe),
        .register_active      (a_active),
        .register_ready       (a_ready),
        .register_status      (a_status),
        .register_read_data   (a_rdata),
        .register_value       (a_value),
        .i_additional_match   (add_match),
        .bit_field_valid      (a_valid),
        .bit_field_read_mask  (a_rmask),
        .bit_field_write_mask (a_wmask),
        .bit_field_write_data (a_wdata),
        .bit_field_read_data  (field),
        .bit_field_value      (field)
    );

    rggen_atomic_wide_register_common #(
        .OFFSET_ADDRESS (8'h10),
        .ATOMIC_WRITE   (1'b0)
    ) dut_nw (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .register_valid       (reg_valid),
        .register_access      (reg_access),
        .register_address     (reg_address),
        .register_write_data  (reg_write_data),
        .register_strobe      (reg_strobe),
        .register_active      (n_active),
        .register_ready       (n_ready),
        .register_status      (n_status),
        .register_read_data   (n_rdata),
        .register_value       (n_value),
        .i_additional_match   (add_match),
        .bit_field_valid      (n_valid),
        .bit_field_read_mask  (n_rmask),
        .bit_field_write_mask (n_wmask),
        .bit_field_write_data (n_wdata),
        .bit_field_read_data  (field),
        .bit_field_value      (field)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reg_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: inputs change on the falling edge, outputs are sampled 2 time
    // units later, and the transfer completes on the following rising edge.
    task automatic apply(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic am, input logic [63:0] fv);
        @(negedge clk);
        reg_valid      = 1'b1;
        reg_access     = wr ? RGGEN_WRITE : RGGEN_READ;
        reg_address    = addr;
        reg_write_data = data;
        reg_strobe     = strb;
        add_match      = am;
        field          = fv;
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        am;
        logic [63:0] field;
        logic        e_active;
        logic        e_valid;
        logic [63:0] e_rmask;
        logic [63:0] e_wmask;
        logic [63:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic am, input logic [63:0] fv,
                                input logic e_active, input logic e_valid, input logic [63:0] e_rmask,
                                input logic [63:0] e_wmask, input logic [63:0] e_wdata,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.am = am; v.field = fv;
        v.e_active = e_active; v.e_valid = e_valid; v.e_rmask = e_rmask;
        v.e_wmask = e_wmask; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    vec_t vecs[$];

    localparam logic [63:0] ONES  = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] UPPER = 64'hFFFFFFFF_00000000;
    localparam logic [63:0] F1    = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] F2    = 64'h12345678_9ABCDEF0;

    initial begin
        rst_n = 1'b0; reg_valid = 1'b0; reg_access = RGGEN_READ; reg_address = '0;
        reg_write_data = '0; reg_strobe = '0; add_match = 1'b1; field = '0;

        //          wr    addr   wdata         strb  am    field  act   val   rmask  wmask                  wdata(masked)          rdata
        vecs.push_back(mk(1'b1, 8'h10, 32'h11112222, 4'hF, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b1, 8'h14, 32'h33334444, 4'hF, 1'b1, 64'h0, 1'b1, 1'b1, 64'h0, ONES, 64'h33334444_11112222, 32'h0));
        vecs.push_back(mk(1'b1, 8'h10, 32'h0000ABCD, 4'h3, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b1, 8'h14, 32'h00000000, 4'h0, 1'b1, 64'h0, 1'b1, 1'b1, 64'h0, 64'h00000000_0000FFFF, 64'h00000000_0000ABCD, 32'h0));
        vecs.push_back(mk(1'b1, 8'h10, 32'hAAAAAAAA, 4'hF, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b1, 8'h10, 32'h000000BB, 4'h1, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b1, 8'h14, 32'hCCCCCCCC, 4'hC, 1'b1, 64'h0, 1'b1, 1'b1, 64'h0, 64'hFFFF0000_FFFFFFFF, 64'hCCCC0000_AAAAAABB, 32'h0));
        vecs.push_back(mk(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, F1, 1'b1, 1'b1, UPPER, 64'h0, 64'h0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, F1, 1'b1, 1'b1, ONES, 64'h0, 64'h0, 32'hCAFEF00D));
        vecs.push_back(mk(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 8'h17, 32'h0, 4'h0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 8'h10, 32'h77777777, 4'hF, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 8'h13, 32'h0, 4'h0, 1'b1, 64'h0, 1'b1, 1'b1, ONES, 64'h0, 64'h0, 32'h00000000));
        vecs.push_back(mk(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, F2, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 32'h00000000));
        vecs.push_back(mk(1'b1, 8'h14, 32'h00000055, 4'h1, 1'b1, F2, 1'b1, 1'b1, 64'h0, 64'h000000FF_FFFFFFFF, 64'h00000055_77777777, 32'h0));
        vecs.push_back(mk(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, F2, 1'b1, 1'b1, UPPER, 64'h0, 64'h0, 32'h12345678));
        vecs.push_back(mk(1'b0, 8'h18, 32'h0, 4'h0, 1'b1, F2, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b0, 8'h0C, 32'h0, 4'h0, 1'b1, F2, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, F2, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));
        vecs.push_back(mk(1'b1, 8'h14, 32'h000000FF, 4'hF, 1'b0, F2, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 32'h0));

        do_reset();
        @(negedge clk);
        #2;
        check("reset_idle_valid", {63'h0, a_valid}, 64'h0);
        check("reset_status", {62'h0, a_status}, {62'h0, RGGEN_OKAY});

        // Table: applied back to back, so each row inherits prior state.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].am, vecs[i].field);
            check($sformatf("v%0d_active", i), {63'h0, a_active}, {63'h0, vecs[i].e_active});
            check($sformatf("v%0d_ready", i), {63'h0, a_ready}, {63'h0, vecs[i].e_active});
            check($sformatf("v%0d_valid", i), {63'h0, a_valid}, {63'h0, vecs[i].e_valid});
            check($sformatf("v%0d_rmask", i), a_rmask, vecs[i].e_rmask);
            check($sformatf("v%0d_wmask", i), a_wmask, vecs[i].e_wmask);
            check($sformatf("v%0d_rdata", i), {32'h0, a_rdata}, {32'h0, vecs[i].e_rdata});
            if (vecs[i].wr && vecs[i].e_valid)
                check($sformatf("v%0d_wdata", i), a_wdata & vecs[i].e_wmask, vecs[i].e_wdata);
            if (vecs[i].e_active)
                check($sformatf("v%0d_value", i), a_value, vecs[i].field);
        end

        // Reset in the middle of a staged sequence drops both staging and snapshot.
        idle();
        apply(1'b1, 8'h10, 32'hDDDDDDDD, 4'hF, 1'b1, F1);
        check("rst_stage_valid", {63'h0, a_valid}, 64'h0);
        apply(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, F1);
        check("rst_latch_valid", {63'h0, a_valid}, 64'h1);
        do_reset();
        apply(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, F2);
        check("rst_read_valid", {63'h0, a_valid}, 64'h1);
        check("rst_read_rmask", a_rmask, UPPER);
        check("rst_read_rdata", {32'h0, a_rdata}, 64'h12345678);
        apply(1'b1, 8'h14, 32'hEEEEEEEE, 4'hF, 1'b1, F2);
        check("rst_commit_valid", {63'h0, a_valid}, 64'h1);
        check("rst_commit_wmask", a_wmask, UPPER);
        check("rst_commit_wdata", a_wdata & UPPER, 64'hEEEEEEEE_00000000);

        // Non-atomic write instance: writes pass straight through and clear the snapshot.
        do_reset();
        apply(1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, 1'b1, 64'h0);
        check("nw_w0_valid", {63'h0, n_valid}, 64'h1);
        check("nw_w0_wmask", n_wmask, 64'h00000000_FFFFFFFF);
        check("nw_w0_wdata", n_wdata & 64'h00000000_FFFFFFFF, 64'h00000000_A5A5A5A5);
        apply(1'b1, 8'h14, 32'h5A5A5A5A, 4'h6, 1'b1, 64'h0);
        check("nw_w1_valid", {63'h0, n_valid}, 64'h1);
        check("nw_w1_wmask", n_wmask, 64'h00FFFF00_00000000);
        apply(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, 64'h11112222_33334444);
        check("nw_latch_valid", {63'h0, n_valid}, 64'h1);
        check("nw_latch_rdata", {32'h0, n_rdata}, 64'h33334444);
        apply(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, 64'h0);
        check("nw_snap_valid", {63'h0, n_valid}, 64'h0);
        check("nw_snap_rdata", {32'h0, n_rdata}, 64'h11112222);
        apply(1'b1, 8'h10, 32'h0, 4'hF, 1'b1, 64'h0);
        check("nw_w2_valid", {63'h0, n_valid}, 64'h1);
        apply(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, 64'h55556666_00000000);
        check("nw_direct_valid", {63'h0, n_valid}, 64'h1);
        check("nw_direct_rmask", n_rmask, UPPER);
        check("nw_direct_rdata", {32'h0, n_rdata}, 64'h55556666);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
